// File: rtl/ts_pkg.sv
// Shared symbol constants and encodings for the per-lane TS1/TS2 receive decoder.
package ts_pkg;
  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] PAD_SYM  = 8'hF7;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam int         TS_LEN   = 16;
  localparam logic [3:0] LAST_SYM = 4'(TS_LEN - 1);

  localparam logic [0:0] ST_HUNT  = 1'b0;
  localparam logic [0:0] ST_PARSE = 1'b1;

  typedef enum logic [1:0] {
    TS_NONE = 2'd0,
    TS_T1   = 2'd1,
    TS_T2   = 2'd2
  } ts_type_e;

  // Only called on an identifier that already passed the TS1/TS2 check.
  function automatic ts_type_e id_to_type(input logic [7:0] id);
    return (id == TS2_ID) ? TS_T2 : TS_T1;
  endfunction
endpackage

// File: rtl/ts_lane_rx.sv
// One lane of the training-sequence decoder: HUNT/PARSE FSM, field capture,
// identical-TS comparator and saturating consecutive counter.
module ts_lane_rx
  import ts_pkg::*;
#(
  parameter int TS_CNT_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        datak_i,
  input  logic        valid_i,
  input  logic        clr_i,
  output logic        ts1_o,
  output logic        ts2_o,
  output logic        err_o,
  output logic [31:0] info_o
);
  localparam logic [3:0] THRESH = 4'(TS_CNT_THRESH);

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  ts_type_e    type_q, type_d, cur_type_q, cur_type_d;
  logic [31:0] info_q, info_d;
  logic [7:0]  tc_q, tc_d;
  logic [7:0]  cur_link_q, cur_link_d, cur_lane_q, cur_lane_d;
  logic [7:0]  cur_nfts_q, cur_nfts_d, cur_rate_q, cur_rate_d, cur_tc_q, cur_tc_d;
  logic        ts1_q, ts1_d, ts2_q, ts2_d, err_q, err_d;
  logic        is_com, sym_ok, same;
  logic [7:0]  cur_id;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= THRESH) ? THRESH : c + 4'd1;
  endfunction

  assign is_com = datak_i && (data_i == COM_SYM);
  assign cur_id = (cur_type_q == TS_T2) ? TS2_ID : TS1_ID;
  assign same   = (type_q == cur_type_q) && (tc_q == cur_tc_q) &&
                  (info_q == {cur_link_q, cur_lane_q, cur_nfts_q, cur_rate_q});

  always_comb begin
    sym_ok = 1'b0;
    if (idx_q <= 4'd2)      sym_ok = !datak_i || (data_i == PAD_SYM);
    else if (idx_q <= 4'd5) sym_ok = !datak_i;
    else if (idx_q == 4'd6) sym_ok = !datak_i && (data_i == TS1_ID || data_i == TS2_ID);
    else                    sym_ok = !datak_i && (data_i == cur_id);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    info_d     = info_q;
    tc_d       = tc_q;
    err_d      = 1'b0;
    cur_type_d = cur_type_q;
    cur_link_d = cur_link_q;
    cur_lane_d = cur_lane_q;
    cur_nfts_d = cur_nfts_q;
    cur_rate_d = cur_rate_q;
    cur_tc_d   = cur_tc_q;
    if (valid_i) begin
      if (state_q == ST_HUNT) begin
        if (is_com) begin
          state_d = ST_PARSE;
          idx_d   = 4'd1;
        end
      end else if (!sym_ok) begin
        // A COM in the wrong place restarts parsing instead of hunting again.
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = is_com ? ST_PARSE : ST_HUNT;
        idx_d   = 4'd1;
      end else begin
        case (idx_q)
          4'd1:    cur_link_d = data_i;
          4'd2:    cur_lane_d = data_i;
          4'd3:    cur_nfts_d = data_i;
          4'd4:    cur_rate_d = data_i;
          4'd5:    cur_tc_d   = data_i;
          4'd6:    cur_type_d = id_to_type(data_i);
          default: ;
        endcase
        if (idx_q == LAST_SYM) begin
          state_d = ST_HUNT;
          cnt_d   = same ? sat_inc(cnt_q) : 4'd1;
          type_d  = cur_type_q;
          tc_d    = cur_tc_q;
          info_d  = {cur_link_q, cur_lane_q, cur_nfts_q, cur_rate_q};
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    end
    if (clr_i) cnt_d = '0;
    ts1_d = (type_d == TS_T1) && (cnt_d == THRESH);
    ts2_d = (type_d == TS_T2) && (cnt_d == THRESH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
      cnt_q   <= '0;
      type_q  <= TS_NONE;
      info_q  <= '0;
      ts1_q   <= 1'b0;
      ts2_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      info_q  <= info_d;
      ts1_q   <= ts1_d;
      ts2_q   <= ts2_d;
      err_q   <= err_d;
    end
  end

  // Field capture needs no reset: a stored type of NONE never matches.
  always_ff @(posedge clk) begin
    tc_q       <= tc_d;
    cur_type_q <= cur_type_d;
    cur_link_q <= cur_link_d;
    cur_lane_q <= cur_lane_d;
    cur_nfts_q <= cur_nfts_d;
    cur_rate_q <= cur_rate_d;
    cur_tc_q   <= cur_tc_d;
  end

  assign ts1_o  = ts1_q;
  assign ts2_o  = ts2_q;
  assign err_o  = err_q;
  assign info_o = info_q;
endmodule

// File: rtl/ts_rx_decoder.sv
// Receive-side TS1/TS2 decoder: one independent ts_lane_rx per lane, with the
// counter clear from core_fsm fanned out to every lane.
module ts_rx_decoder #(
  parameter int LANE_NUM      = 4,
  parameter int TS_CNT_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*LANE_NUM-1:0] rx_data,
  input  logic [LANE_NUM-1:0]   rx_datak,
  input  logic [LANE_NUM-1:0]   rx_valid,
  input  logic                  ts_cnt_clr,
  output logic [LANE_NUM-1:0]   ts1_p2c,
  output logic [LANE_NUM-1:0]   ts2_p2c,
  output logic [32*LANE_NUM-1:0] lane_info,
  output logic [LANE_NUM-1:0]   ts_err
);
  for (genvar n = 0; n < LANE_NUM; n++) begin : g_lane
    ts_lane_rx #(
      .TS_CNT_THRESH(TS_CNT_THRESH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (rx_data[8*n +: 8]),
      .datak_i(rx_datak[n]),
      .valid_i(rx_valid[n]),
      .clr_i  (ts_cnt_clr),
      .ts1_o  (ts1_p2c[n]),
      .ts2_o  (ts2_p2c[n]),
      .err_o  (ts_err[n]),
      .info_o (lane_info[32*n +: 32])
    );
  end
endmodule

// File: doc/ts_rx_decoder.md
# ts_rx_decoder

Per-lane receive-side training-sequence decoder that sits directly upstream of `core_fsm`. It parses the 16-symbol TS1/TS2 ordered-set stream on each lane and counts consecutive identical ordered sets. It drives the per-lane `ts1_p2c`/`ts2_p2c` qualifiers that `core_fsm` uses for Polling/Config transitions. It also exports the captured link/lane/N_FTS/rate fields for the FSM's per-lane info registers.

## Interface
Parameters:
- `LANE_NUM`, default 4: number of lanes; matches the global `` `LANE_NUM``.
- `TS_CNT_THRESH`, default 8: number of consecutive identical TS needed to assert a qualifier; legal range 1–15.

Ports:
- `clk` input 1: 1 GHz system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `rx_data` input 8*LANE_NUM: received symbol per lane; lane n occupies `[8n+7:8n]`.
- `rx_datak` input LANE_NUM: K-symbol flag per lane.
- `rx_valid` input LANE_NUM: symbol valid per lane.
- `ts_cnt_clr` input 1: one-cycle pulse from `core_fsm` on a sub-state change; clears all counters.
- `ts1_p2c` output LANE_NUM: lane has received `TS_CNT_THRESH` consecutive identical TS1.
- `ts2_p2c` output LANE_NUM: same condition for TS2.
- `lane_info` output 32*LANE_NUM: per lane `{link_num, lane_num, n_fts, rate_id}` from the last complete TS.
- `ts_err` output LANE_NUM: one-cycle pulse on a malformed ordered set.

## Operation
- Lanes are fully independent. Each lane runs a 2-state FSM:
  - HUNT: wait for a COM symbol.
  - PARSE: consume symbols 1..15, tracked by a 4-bit symbol index.
- A cycle with `rx_valid[n]`=0 is a stall: no state, index or counter change on lane n.
- HUNT → PARSE on a valid COM (`rx_datak`=1, data 8'hBC). Index is set to 1.
- Symbol checks in PARSE:
  - Sym 1–2 (link, lane): D-symbol, or K PAD (8'hF7).
  - Sym 3–5 (N_FTS, rate_id, training control): D-symbol.
  - Sym 6: D-symbol equal to 8'h4A (TS1) or 8'h45 (TS2). This latches the TS type.
  - Sym 7–15: D-symbol equal to the latched type ID.
- Any check failure:
  - Pulse `ts_err`.
  - Clear the consecutive count to 0 and deassert both qualifiers.
  - Go to HUNT.
  - Exception: if the failing symbol is itself a COM, pulse `ts_err` and go to PARSE with index 1 (resync).
- Completion happens when sym 15 is accepted:
  - If the type and sym 1–5 match the previously stored TS, the count increments, saturating at `TS_CNT_THRESH`.
  - Otherwise the count is set to 1 and the new type and fields are stored.
  - `lane_info` updates to the new fields in both cases.
  - FSM returns to HUNT.
- Qualifiers:
  - `ts1_p2c[n]` = (stored type == TS1) && (count == `TS_CNT_THRESH`).
  - `ts2_p2c[n]` is the TS2 equivalent.
  - The qualifier stays high while identical TS keep arriving.
- `ts_cnt_clr`:
  - Zeroes all lane counts and deasserts all qualifiers.
  - Does not abort a TS in progress. If that TS completes, it counts as 1.
  - `lane_info` is kept.
- If `ts_cnt_clr` and a completion occur in the same cycle, `ts_cnt_clr` wins. The count becomes 0 and the stored fields still update.
- Reset values: all outputs 0, FSM in HUNT, counts 0.
- Reset asserted mid-ordered-set returns the lane to HUNT on the next edge. No partial TS is counted.

## Timing
- Outputs are registered.
- `ts1_p2c`/`ts2_p2c`/`lane_info` change on the clock edge that accepts sym 15. They are visible the cycle after sym 15 is presented.
- `ts_err` is high on the cycle after the offending symbol, for exactly one cycle.
- `ts_cnt_clr` takes effect on the next edge. Qualifiers are low the cycle after the pulse.
- Minimum TS spacing is zero: a COM immediately after sym 15 is accepted back-to-back.

## Structure
- Package `ts_pkg` holds:
  - Constants: `COM_SYM`=8'hBC, `PAD_SYM`=8'hF7, `TS1_ID`=8'h4A, `TS2_ID`=8'h45, `TS_LEN`=16.
  - Lane FSM state encoding (HUNT, PARSE).
  - TS type encoding (NONE, TS1, TS2).
- Sub-module `ts_lane_rx` implements one lane: FSM, index, field registers, comparator and counter.
- `ts_rx_decoder` instantiates `LANE_NUM` copies of `ts_lane_rx` in a generate loop and fans out `ts_cnt_clr`.

## Test plan
- All lanes receive 8 identical TS1 (link 0, lane n, N_FTS 8'h20, rate 8'h02) → `ts1_p2c`=4'hF the cycle after the 8th sym 15; `lane_info[31:0]`=32'h0000_2002.
- Lane 2, 5th TS has link number 8'h01 → lane 2 count restarts at 1; `ts1_p2c[2]` rises only after 7 further identical TS (12th TS overall).
- Lane 1, sym 9 = 8'h45 inside a TS1 → `ts_err[1]` pulses once, count is 0, `ts1_p2c[1]`=0; the next 8 clean TS1 reassert it.
- COM injected at sym 10 → `ts_err` pulse and resync; the following 15 symbols complete a valid TS with count 1.
- Random `rx_valid` gaps (~30% low) on 8 TS2 → `ts2_p2c` asserts exactly once, after the 8th completed TS2; no errors.
- `ts_cnt_clr` while `ts1_p2c`=4'hF, and `rst_n` low mid-TS → qualifiers 0 the next cycle and `lane_info` kept; after reset all outputs 0 and the partial TS is not counted.
